jtcop_objdma: RTL

//  Object-RAM DMA controller and port arbiter. On the CPU's obj_copy strobe it copies
//  the whole object table from object RAM into the sprite line-buffer RAM.
//  It shares the single object-RAM port between CPU reads/writes and DMA reads.
//  It also reports a busy flag that the main CPU DTACK logic adds to its bus_busy term.

---
 rtl/jtcop_objdma.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/jtcop_objdma.sv
// jtcop_objdma - object-RAM to sprite line-buffer DMA and object-RAM port arbiter.
//
// A copy_req strobe from the CPU copies all 2**AW words of the object table
// (bank chosen by mixpsel at start) into the sprite buffer. The single object-RAM
// port is shared: the CPU owns it while the DMA is idle or arming, and the DMA
// owns it from the first read until the done pulse, stalling CPU accesses.
//
// Optional build macro: JTCOP_OBJDMA_VBWAIT_EN
//   Defined   - a copy starts only after a falling edge of LVBL (start of vblank)
//               seen after the request.
//   Undefined - a copy starts as soon as the CPU releases the port; LVBL unused.

module jtcop_objdma #(
    parameter int AW     = 10,
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          copy_req,
    input  logic          mixpsel,
    input  logic          cpu_cs,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_busy,
    output logic [AW:0]   ram_addr,
    output logic          ram_cs,
    input  logic [15:0]   ram_dout,
    input  logic          ram_ok,
    output logic [AW-1:0] buf_addr,
    output logic [15:0]   buf_din,
    output logic          buf_we,
    output logic          dma_busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RD,
        WR,
        DONE
    } state_t;

    // Settle counter load value: SETTLE-1 extra clocks before ram_ok is trusted
    localparam logic [1:0] SETTLE_LD = 2'(SETTLE - 1);

    state_t        state;
    logic [AW-1:0] cnt;
    logic          bank;
    logic          pending;
    logic [1:0]    settle_cnt;
    logic          arm_go;
    logic          dma_own;

`ifdef JTCOP_OBJDMA_VBWAIT_EN
    logic lvbl_l;
    logic vb_seen;
    logic vb_fall;

    assign vb_fall = lvbl_l & ~LVBL;
    assign arm_go  = ~cpu_cs & (vb_seen | vb_fall);

    // Remember a vblank start seen while armed; forget it whenever not armed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvbl_l  <= 1'b0;
            vb_seen <= 1'b0;
        end else begin
            lvbl_l <= LVBL;
            if (state != ARM) begin
                vb_seen <= 1'b0;
            end else if (vb_fall) begin
                vb_seen <= 1'b1;
            end
        end
    end
`else
    logic unused_lvbl;

    assign unused_lvbl = LVBL;
    assign arm_go      = ~cpu_cs;
`endif

    // Port mux: CPU owns the object RAM until the first DMA read, DMA until done
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        dma_own = (state == RD) || (state == WR) || (state == DONE);
        if (dma_own) begin
            ram_addr = {bank, cnt};
            ram_cs   = (state == RD);
            cpu_busy = cpu_cs;
        end else begin
            ram_addr = {1'b0, cpu_addr};
            ram_cs   = cpu_cs;
            cpu_busy = 1'b0;
        end
    end

    // Copy sequencer: one RD/WR pair per word, buffer-side outputs registered
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bank       <= 1'b0;
            pending    <= 1'b0;
            settle_cnt <= '0;
            buf_addr   <= '0;
            buf_din    <= '0;
            buf_we     <= 1'b0;
            dma_busy   <= 1'b0;
            done       <= 1'b0;
        end else begin
            buf_we <= 1'b0;
            done   <= 1'b0;

            // A single request may queue behind a running copy; extras are dropped
            if (state == IDLE && (copy_req || pending)) begin
                pending <= 1'b0;
            end else if (copy_req && dma_busy) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (copy_req || pending) begin
                        dma_busy <= 1'b1;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    if (arm_go) begin
                        bank       <= mixpsel;
                        settle_cnt <= SETTLE_LD;
                        state      <= RD;
                    end
                end
                RD: begin
                    if (settle_cnt != 2'd0) begin
                        settle_cnt <= settle_cnt - 2'd1;
                    end else if (ram_ok) begin
                        buf_din  <= ram_dout;
                        buf_addr <= cnt;
                        buf_we   <= 1'b1;
                        state    <= WR;
                    end
                end
                WR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        settle_cnt <= SETTLE_LD;
                        state      <= RD;
                    end
                end
                DONE: begin
                    dma_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
